// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the requesters/transmitter and the shared UART transmit scheduler.
// master = scheduler side, slave = requesters plus the transmitter.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic                      baud_tclk;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_done;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        input  req, req_data, tx_done,
        output grant, ack, baud_tclk, tx_data, tx_start, busy, err_timeout
    );

    modport slave (
        output req, req_data, tx_done,
        input  grant, ack, baud_tclk, tx_data, tx_start, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters,
// with a free-running baud tick generator and a done-timeout abort.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned CLKS_PER_BAUD = 16,
    parameter int unsigned TIMEOUT_BAUDS = 16
) (
    input  logic                clk1,
    input  logic                rst,
    uart_tx_scheduler_if.master bus
);
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BAUD);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_BAUDS + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic                baud_q, baud_d;
    logic [TO_W-1:0]     tout_q, tout_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic                any_req_c;
    logic [PTR_W-1:0]    sel_c;
    logic [PTR_W-1:0]    win_inc_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Baud tick is registered one count early so it lines up with counter == CLKS_PER_BAUD-1.
    always_comb begin
        baud_cnt_d = (baud_cnt_q == BAUD_W'(CLKS_PER_BAUD - 1)) ? '0 : baud_cnt_q + BAUD_W'(1);
        baud_d     = (baud_cnt_q == BAUD_W'(CLKS_PER_BAUD - 2));
    end

    // First requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W-1:0] idx;
        any_req_c = 1'b0;
        sel_c     = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!any_req_c && bus.req[idx]) begin
                any_req_c = 1'b1;
                sel_c     = idx;
            end
        end
    end

    assign win_inc_c = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        tout_d     = tout_q;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d        = START;
                    win_d          = sel_c;
                    grant_d        = '0;
                    grant_d[sel_c] = 1'b1;
                    tx_data_d      = data_arr[sel_c];
                    tx_start_d     = 1'b1;
                end
            end
            START: begin
                tout_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done pulse takes priority over a coincident final timeout tick.
                if (bus.tx_done) begin
                    state_d      = RELEASE;
                    ack_d[win_q] = 1'b1;
                end else if (baud_q) begin
                    if (tout_q == TO_W'(TIMEOUT_BAUDS - 1)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        ptr_d   = win_inc_c;
                        state_d = IDLE;
                    end else begin
                        tout_d = tout_q + TO_W'(1);
                    end
                end
            end
            RELEASE: begin
                grant_d = '0;
                ptr_d   = win_inc_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            baud_q     <= 1'b0;
            tout_q     <= '0;
            ptr_q      <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            baud_q     <= baud_d;
            tout_q     <= tout_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.baud_tclk   = baud_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed plus randomized bench for uart_tx_scheduler against a transaction-level
// round-robin / baud / timeout reference model.
module tb_uart_tx_scheduler;
    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 16;
    localparam int unsigned TO  = 16;

    logic clk1 = 1'b0;
    logic rst;

    uart_tx_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(N), .DATA_W(DW), .CLKS_PER_BAUD(CPB), .TIMEOUT_BAUDS(TO)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;           // edges since the last reset edge
    int ptr   = 0;           // model round-robin pointer
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int w);
        return N'(1 << w);
    endfunction

    function automatic logic [DW-1:0] byte_of(input int w);
        return DW'(bus.req_data >> (w * DW));
    endfunction

    function automatic int pick();
        int r;
        r = 32'(bus.req);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (((r >> idx) & 1) == 1) return idx;
        end
        return 0;
    endfunction

    task automatic set_byte(input int i, input logic [DW-1:0] v);
        logic [N*DW-1:0] m;
        m = (N*DW)'({DW{1'b1}}) << (i * DW);
        bus.req_data = (bus.req_data & ~m) | ((N*DW)'(v) << (i * DW));
    endtask

    // One clock; baud tick and bus invariants are checked every cycle.
    task automatic step();
        @(posedge clk1);
        #1;
        if (rst) ncyc = 0;
        else     ncyc++;
        chk("baud_tclk", 32'(bus.baud_tclk), 32'((ncyc % CPB) == (CPB - 1)));
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        chk("ack_err_excl", 32'((|bus.ack) & bus.err_timeout), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst       = 1'b0;
        ptr       = 0;
        last_data = '0;
    endtask

    // mode 0: done after dly wait cycles; 1: never done (timeout); 2: done on the final timeout tick.
    task automatic run_txn(input int mode, input int dly, input bit drop, input bit scr);
        int w;
        int ticks;
        bit fin;
        logic [DW-1:0] d;
        w = pick();
        d = byte_of(w);
        step();
        chk("grant", 32'(bus.grant), 32'(oh(w)));
        chk("tx_start", 32'(bus.tx_start), 32'd1);
        chk("tx_data", 32'(bus.tx_data), 32'(d));
        chk("busy", 32'(bus.busy), 32'd1);
        chk("ack_at_grant", 32'(bus.ack), 32'd0);
        last_data = d;
        if (scr)  set_byte(w, ~d);
        if (drop) bus.req = bus.req & ~oh(w);
        step();
        chk("tx_start_pulse", 32'(bus.tx_start), 32'd0);
        chk("tx_data_held", 32'(bus.tx_data), 32'(d));
        ticks = 0;
        fin   = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if ((ncyc % CPB) == (CPB - 1)) ticks++;
            if ((mode == 0 && k == dly) || (mode == 2 && ticks == TO)) begin
                bus.tx_done = 1'b1;
                step();
                bus.tx_done = 1'b0;
                chk("ack", 32'(bus.ack), 32'(oh(w)));
                chk("grant_in_release", 32'(bus.grant), 32'(oh(w)));
                chk("err_on_done", 32'(bus.err_timeout), 32'd0);
                chk("tx_data_release", 32'(bus.tx_data), 32'(d));
                step();
                chk("grant_dropped", 32'(bus.grant), 32'd0);
                chk("ack_one_cycle", 32'(bus.ack), 32'd0);
                chk("busy_idle", 32'(bus.busy), 32'd0);
                fin = 1'b1;
            end else if (ticks == TO) begin
                step();
                chk("err_timeout", 32'(bus.err_timeout), 32'd1);
                chk("grant_after_err", 32'(bus.grant), 32'd0);
                chk("ack_after_err", 32'(bus.ack), 32'd0);
                chk("busy_after_err", 32'(bus.busy), 32'd0);
                fin = 1'b1;
            end else begin
                step();
                chk("wait_ack", 32'(bus.ack), 32'd0);
                chk("wait_err", 32'(bus.err_timeout), 32'd0);
                chk("wait_grant", 32'(bus.grant), 32'(oh(w)));
            end
        end
        if (!fin) chk("txn_bound", 32'(fin), 32'd1);
        ptr = (w + 1) % N;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;

        // reset and baud cadence
        do_reset();
        repeat (40) step();

        // single request
        set_byte(0, 8'hA5);
        bus.req = 4'b0001;
        run_txn(0, 20, 1'b0, 1'b0);
        bus.req = '0;
        step();
        chk("idle_after_single", 32'(bus.grant), 32'd0);

        // contention from pointer 0: order 0,1,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_byte(i, DW'(8'h10 + i));
        bus.req = 4'b1011;
        repeat (4) run_txn(0, int'($urandom_range(0, 30)), 1'b0, 1'b0);

        // fairness: serve 1, then 0 and 1 contend from pointer 2
        bus.req = 4'b0010;
        run_txn(0, 5, 1'b0, 1'b0);
        bus.req = 4'b0011;
        run_txn(0, 3, 1'b0, 1'b0);
        run_txn(0, 3, 1'b0, 1'b0);

        // timeout on requester 2, then 3 is served
        bus.req = 4'b1100;
        run_txn(1, 0, 1'b0, 1'b0);
        run_txn(0, 7, 1'b0, 1'b0);
        bus.req = 4'b0100;
        run_txn(2, 0, 1'b0, 1'b0);

        // stray done in IDLE
        bus.req     = '0;
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("stray_ack", 32'(bus.ack), 32'd0);
        chk("stray_busy", 32'(bus.busy), 32'd0);
        step();
        chk("stray_ack_late", 32'(bus.ack), 32'd0);
        chk("stray_grant", 32'(bus.grant), 32'd0);

        // reset mid-transaction clears pointer and emits nothing
        bus.req = 4'b0010;
        run_txn(0, 2, 1'b0, 1'b0);
        bus.req = 4'b0100;
        step();
        chk("pre_rst_grant", 32'(bus.grant), 32'(4'b0100));
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_err", 32'(bus.err_timeout), 32'd0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst       = 1'b0;
        ptr       = 0;
        last_data = '0;
        bus.req   = 4'b0101;
        run_txn(0, 4, 1'b0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int r;
            int mode;
            bit keep;
            keep = ($urandom_range(0, 2) == 0) && (bus.req != '0);
            if (!keep) begin
                int gap;
                gap     = int'($urandom_range(0, 3));
                bus.req = '0;
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("gap_grant", 32'(bus.grant), 32'd0);
                    chk("gap_busy", 32'(bus.busy), 32'd0);
                    chk("gap_tx_data", 32'(bus.tx_data), 32'(last_data));
                end
                bus.req = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++) set_byte(i, DW'($urandom));
            end
            r    = int'($urandom_range(0, 9));
            mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            run_txn(mode, int'($urandom_range(0, 60)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
